fetch_unit: RTL
===============

# fetch_unit

Instruction fetch/issue sequencer feeding the control decoder. It walks the PC through instruction memory with a req/ack handshake and latches each instruction word. It presents the decoded fields (format, opcode, sign) to the decoder, then consumes the decoder's halt/branch/jump outputs to select the next PC. It sits between instruction memory and the control/datapath and owns the processor's run/halt state.

## Interface
- PCW, 10, PC / instruction-address width
- IW, 9, instruction word width; fields: format = ir[8], opcode = ir[7:4], sign = ir[3]
- OFFW, 6, signed branch offset width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; one clock, reset async active-high
- start  in  1  single-cycle pulse; begins execution at PC 0 from IDLE
- imem_req  out  1  fetch request
- imem_addr  out  PCW  fetch address (= pc)
- imem_ack  in  1  memory has valid imem_data this cycle
- imem_data  in  IW  instruction word
- format  out  1  ir[8]
- opcode  out  4  ir[7:4]
- sign  out  1  ir[3]
- instr_valid  out  1  fields are a live instruction being issued
- halt  in  1  decoder halt
- branch  in  1  decoder branch
- jump  in  1  decoder jump
- br_cond  in  1  datapath branch condition
- br_offset  in  OFFW  signed PC-relative branch offset
- jump_target  in  PCW  absolute jump target
- exec_stall  in  1  datapath holds the current instruction
- halted  out  1  processor stopped
- pc  out  PCW  current PC
- icount  out  16  retired-instruction count

## Operation
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE: all handshakes low. start=1 -> FETCH with pc=0, icount=0. start is ignored in every other state.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack=1: ir<=imem_data -> ISSUE. Otherwise hold FETCH and keep req high. imem_ack is ignored outside FETCH.
- ISSUE: instr_valid=1. format/opcode/sign are combinational from ir and always reflect ir. If exec_stall=1, stay in ISSUE and change nothing. Otherwise retire: icount+1, then select by priority:
  - halt -> HALTED, pc unchanged
  - else jump -> pc<=jump_target, FETCH
  - else branch & br_cond -> pc<=pc + sign-extended br_offset, FETCH
  - else pc<=pc+1, FETCH
- HALTED: halted=1; all other handshakes low. Only reset exits this state.
- All PC arithmetic is modulo 2^PCW. pc+1 from 2^PCW-1 wraps to 0. A negative offset below 0 wraps.
- icount wraps from 0xFFFF to 0.
- halt/branch/jump/br_cond are sampled only in ISSUE with exec_stall=0.

## Timing
- Reset (async, any state, including mid-handshake): state=IDLE, pc=0, ir=0, icount=0, imem_req=0, instr_valid=0, halted=0. format/opcode/sign read 0 immediately.
- start sampled at edge t -> imem_req=1 in cycle t+1.
- imem_ack in cycle k (may equal the first req cycle) -> instr_valid=1 in cycle k+1.
- Minimum 2 cycles per instruction (FETCH+ISSUE with zero-wait ack).
- Next fetch address is visible on imem_addr the cycle after the retiring ISSUE cycle.
- instr_valid is exactly one cycle per instruction unless exec_stall extends it.
- halted rises the cycle after the halting ISSUE cycle.

## Test plan
- Sequential: reset, start; memory acks immediately; words 0x000..0x003 with no control inputs -> imem_addr 0,1,2,3 on alternate cycles; instr_valid every other cycle; icount=4 after 8 cycles.
- Wait states: ack delayed 3 cycles at pc=5 -> imem_req held 4 cycles, addr stable at 5; imem_data=0x1A8 -> format=1, opcode=0xA, sign=1.
- Control flow at pc=0x010:
  - jump=1, jump_target=0x3FF -> next addr 0x3FF; fall-through from there -> addr 0x000 (wrap).
  - branch=1, br_cond=1, br_offset=-3 -> addr 0x00D.
  - br_cond=0 -> addr 0x011.
  - halt=1, jump=1 simultaneously -> HALTED; pc stays 0x010.
- Stall: exec_stall=1 for 2 cycles in ISSUE -> instr_valid high 3 cycles; icount +1 only.
- Halt/start: after halt, start pulse -> stays HALTED, no imem_req. Reset asserted mid-FETCH -> imem_req drops without waiting for a clock; a subsequent start fetches addr 0.

Source files
------------

// File: rtl/fetch_if.sv
// Instruction-memory and decoder-facing bundle for the fetch/issue sequencer.
interface fetch_if #(
   parameter int unsigned PCW  = 10,
   parameter int unsigned IW   = 9,
   parameter int unsigned OFFW = 6
);
   // instruction memory handshake
   logic            imem_req;
   logic [PCW-1:0]  imem_addr;
   logic            imem_ack;
   logic [IW-1:0]   imem_data;

   // decoded fields presented to the control decoder
   logic            format;
   logic [3:0]      opcode;
   logic            sign;
   logic            instr_valid;

   // decoder / datapath feedback used to pick the next pc
   logic            halt;
   logic            branch;
   logic            jump;
   logic            br_cond;
   logic [OFFW-1:0] br_offset;
   logic [PCW-1:0]  jump_target;
   logic            exec_stall;

   // sequencer side
   modport master (
      output imem_req, imem_addr, format, opcode, sign, instr_valid,
      input  imem_ack, imem_data, halt, branch, jump, br_cond,
             br_offset, jump_target, exec_stall
   );

   // memory / decoder / datapath side
   modport slave (
      input  imem_req, imem_addr, format, opcode, sign, instr_valid,
      output imem_ack, imem_data, halt, branch, jump, br_cond,
             br_offset, jump_target, exec_stall
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch/issue sequencer: walks pc through imem with req/ack,
// latches the word, issues its fields, then picks the next pc from the
// decoder's halt/jump/branch outcome. Owns the run/halt state.
module fetch_unit #(
   parameter int unsigned PCW  = 10,
   parameter int unsigned IW   = 9,
   parameter int unsigned OFFW = 6
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   fetch_if.master        bus,
   output logic           halted,
   output logic [PCW-1:0] pc,
   output logic [15:0]    icount
);

   localparam int unsigned CNTW    = 16;
   localparam int unsigned FMT_BIT = IW - 1;
   localparam int unsigned OPC_MSB = IW - 2;
   localparam int unsigned SGN_BIT = IW - 6;
   localparam int unsigned EXTW    = PCW - OFFW;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      ISSUE  = 2'd2,
      HALTED = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [PCW-1:0]  pc_nxt;
   logic [IW-1:0]   ir, ir_nxt;
   logic [CNTW-1:0] icount_nxt;
   logic            imem_req_q;
   logic            instr_valid_q;
   logic            halted_q;
   logic [PCW-1:0]  off_ext;

   // sign-extend the branch offset to pc width; the add then wraps mod 2^PCW
   assign off_ext = {{EXTW{bus.br_offset[OFFW-1]}}, bus.br_offset};

   // next-state, next-pc, instruction latch and retire count
   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc;
      ir_nxt     = ir;
      icount_nxt = icount;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt  = FETCH;
               pc_nxt     = '0;
               icount_nxt = '0;
            end
         end
         FETCH: begin
            if (bus.imem_ack) begin
               ir_nxt    = bus.imem_data;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (!bus.exec_stall) begin
               icount_nxt = icount + CNTW'(1);
               if (bus.halt) begin
                  state_nxt = HALTED;
               end else if (bus.jump) begin
                  pc_nxt    = bus.jump_target;
                  state_nxt = FETCH;
               end else if (bus.branch && bus.br_cond) begin
                  pc_nxt    = pc + off_ext;
                  state_nxt = FETCH;
               end else begin
                  pc_nxt    = pc + PCW'(1);
                  state_nxt = FETCH;
               end
            end
         end
         HALTED: begin
            state_nxt = HALTED;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // state, architectural registers and registered handshake outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         pc            <= '0;
         ir            <= '0;
         icount        <= '0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state         <= state_nxt;
         pc            <= pc_nxt;
         ir            <= ir_nxt;
         icount        <= icount_nxt;
         imem_req_q    <= (state_nxt == FETCH);
         instr_valid_q <= (state_nxt == ISSUE);
         halted_q      <= (state_nxt == HALTED);
      end
   end

   // fields always mirror ir, so they read zero straight out of reset
   assign bus.format      = ir[FMT_BIT];
   assign bus.opcode      = ir[OPC_MSB -: 4];
   assign bus.sign        = ir[SGN_BIT];
   assign bus.imem_req    = imem_req_q;
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = instr_valid_q;
   assign halted          = halted_q;

endmodule
